plab3_mem_coherence_responder_l1: RTL and testbench

L1-side responder for the L2 coherence channel. It accepts one coherence request at a time from the L2 bank (INV, WB, WBINV) and probes the L1 tag/data arrays through a single-cycle probe port. It then invalidates and/or cleans the matching line as required, and returns an acknowledgement or a dirty line to the L2. It sits beside the L1 blocking cache controller and stalls that controller while a request is in flight.

---
 rtl/plab3_mem_coherence_responder_l1_pkg.sv | 38 +++
 rtl/plab3_mem_coherence_responder_l1_if.sv | 39 +++
 rtl/plab3_mem_coherence_responder_l1_dpath.sv | 84 ++++++++
 rtl/plab3_mem_coherence_responder_l1.sv | 114 +++++++++++
 tb/tb_plab3_mem_coherence_responder_l1.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/plab3_mem_coherence_responder_l1_pkg.sv
// Shared definitions for the L1 coherence responder: message type codes,
// FSM state encoding and the coherence message width helper.
package plab3_mem_coherence_responder_l1_pkg;

    localparam int c_type_nbits = 3;

    // Request types issued by the L2 bank
    localparam logic [c_type_nbits-1:0] COH_INV   = 3'd0;
    localparam logic [c_type_nbits-1:0] COH_WB    = 3'd1;
    localparam logic [c_type_nbits-1:0] COH_WBINV = 3'd2;

    // Response types returned to the L2 bank
    localparam logic [c_type_nbits-1:0] COH_ACK  = 3'd0;
    localparam logic [c_type_nbits-1:0] COH_DATA = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_CHECK = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Message layout, MSB first: {type, opaque, addr, len, data}
    function automatic int coh_len_nbits(int line_nbits);
        return $clog2(line_nbits / 8);
    endfunction

    function automatic int coh_msg_nbits(int opaque_nbits, int addr_nbits, int line_nbits);
        return c_type_nbits + opaque_nbits + addr_nbits + coh_len_nbits(line_nbits) + line_nbits;
    endfunction

    // A dirty hit on a writeback-style request must ship the line back
    function automatic logic coh_has_data(logic [c_type_nbits-1:0] req_type,
                                          logic hit, logic dirty);
        return hit && dirty && ((req_type == COH_WB) || (req_type == COH_WBINV));
    endfunction

endpackage

// File: rtl/plab3_mem_coherence_responder_l1_if.sv
// Coherence channel between the L2 bank (master) and the L1 responder (slave):
// request and response val/rdy handshakes with packed messages.
interface plab3_mem_coherence_responder_l1_if
    import plab3_mem_coherence_responder_l1_pkg::*;
#(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_line_nbits   = 128
);

    localparam int c_msg_nbits = coh_msg_nbits(p_opaque_nbits, p_addr_nbits, p_line_nbits);

    logic [c_msg_nbits-1:0] coherereq_msg;
    logic                   coherereq_val;
    logic                   coherereq_rdy;

    logic [c_msg_nbits-1:0] cohereresp_msg;
    logic                   cohereresp_val;
    logic                   cohereresp_rdy;

    modport master (
        output coherereq_msg,
        output coherereq_val,
        input  coherereq_rdy,
        input  cohereresp_msg,
        input  cohereresp_val,
        output cohereresp_rdy
    );

    modport slave (
        input  coherereq_msg,
        input  coherereq_val,
        output coherereq_rdy,
        output cohereresp_msg,
        output cohereresp_val,
        input  cohereresp_rdy
    );

endinterface

// File: rtl/plab3_mem_coherence_responder_l1_dpath.sv
// Datapath for the coherence responder: holds the accepted request fields,
// security domain and captured line, and builds the response message.
module plab3_mem_coherence_responder_l1_dpath
    import plab3_mem_coherence_responder_l1_pkg::*;
#(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_line_nbits   = 128,
    parameter int p_msg_nbits    = coh_msg_nbits(p_opaque_nbits, p_addr_nbits, p_line_nbits)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [p_msg_nbits-1:0]    req_msg,
    input  logic                      req_sd,
    input  logic                      req_load,
    input  logic                      probe_sample,
    input  logic                      probe_hit,
    input  logic                      probe_dirty,
    input  logic [p_line_nbits-1:0]   probe_data,
    output logic [c_type_nbits-1:0]   req_type,
    output logic [p_addr_nbits-1:0]   probe_addr,
    output logic                      probe_sd,
    output logic [p_msg_nbits-1:0]    resp_msg
);

    localparam int c_len_nbits   = coh_len_nbits(p_line_nbits);
    localparam int c_addr_lsb    = p_line_nbits + c_len_nbits;
    localparam int c_opaque_lsb  = c_addr_lsb + p_addr_nbits;
    localparam int c_type_lsb    = c_opaque_lsb + p_opaque_nbits;

    logic [c_type_nbits-1:0]   type_reg;
    logic [p_opaque_nbits-1:0] opaque_reg;
    logic [p_addr_nbits-1:0]   addr_reg;
    logic                      sd_reg;
    logic                      has_data_reg;
    logic [p_line_nbits-1:0]   data_reg;
    logic                      has_data_now;

    // Incoming len/data fields carry nothing for a coherence request
    logic unused_req_bits;
    assign unused_req_bits = ^req_msg[c_addr_lsb-1:0];

    assign has_data_now = coh_has_data(type_reg, probe_hit, probe_dirty);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            type_reg   <= '0;
            opaque_reg <= '0;
            addr_reg   <= '0;
            sd_reg     <= 1'b0;
        end else if (req_load) begin
            type_reg   <= req_msg[c_type_lsb +: c_type_nbits];
            opaque_reg <= req_msg[c_opaque_lsb +: p_opaque_nbits];
            addr_reg   <= req_msg[c_addr_lsb +: p_addr_nbits];
            sd_reg     <= req_sd;
        end
    end

    // Probe result sampled in CHECK; line kept only when it must be returned
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            has_data_reg <= 1'b0;
            data_reg     <= '0;
        end else if (probe_sample) begin
            has_data_reg <= has_data_now;
            if (has_data_now) begin
                data_reg <= probe_data;
            end
        end
    end

    assign req_type   = type_reg;
    assign probe_sd   = sd_reg;
    assign probe_addr = {addr_reg[p_addr_nbits-1:c_len_nbits], {c_len_nbits{1'b0}}};

    assign resp_msg = {
        (has_data_reg ? COH_DATA : COH_ACK),
        opaque_reg,
        addr_reg,
        {c_len_nbits{1'b0}},
        (has_data_reg ? data_reg : {p_line_nbits{1'b0}})
    };

endmodule

// File: rtl/plab3_mem_coherence_responder_l1.sv
// L1-side coherence responder: serves one L2 request at a time, probes the L1
// arrays, issues invalidate/clean strobes and returns an ack or dirty line.
module plab3_mem_coherence_responder_l1
    import plab3_mem_coherence_responder_l1_pkg::*;
#(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_line_nbits   = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    plab3_mem_coherence_responder_l1_if.slave coh,
    output logic                     probe_en,
    output logic [p_addr_nbits-1:0]  probe_addr,
    input  logic                     probe_hit,
    input  logic                     probe_dirty,
    input  logic [p_line_nbits-1:0]  probe_data,
    output logic                     inval_en,
    output logic                     clean_en,
    output logic                     l1_stall,
    input  logic                     sd,
    output logic                     probe_sd
);

    localparam int c_msg_nbits = coh_msg_nbits(p_opaque_nbits, p_addr_nbits, p_line_nbits);

    state_t                  state;
    state_t                  state_next;
    logic                    req_rdy;
    logic                    resp_val;
    logic                    req_load;
    logic                    probe_sample;
    logic [c_type_nbits-1:0] req_type;
    logic [c_msg_nbits-1:0]  resp_msg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        req_rdy      = 1'b0;
        resp_val     = 1'b0;
        req_load     = 1'b0;
        probe_en     = 1'b0;
        probe_sample = 1'b0;
        inval_en     = 1'b0;
        clean_en     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req_rdy = 1'b1;
                if (coh.coherereq_val) begin
                    req_load   = 1'b1;
                    state_next = ST_PROBE;
                end
            end
            ST_PROBE: begin
                probe_en   = 1'b1;
                state_next = ST_CHECK;
            end
            ST_CHECK: begin
                probe_sample = 1'b1;
                // WBINV drops the line, so cleaning it would be pointless
                if (probe_hit) begin
                    case (req_type)
                        COH_INV:   inval_en = 1'b1;
                        COH_WB:    clean_en = probe_dirty;
                        COH_WBINV: inval_en = 1'b1;
                        default:   ;
                    endcase
                end
                state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_val = 1'b1;
                if (coh.cohereresp_rdy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign l1_stall           = (state != ST_IDLE);
    assign coh.coherereq_rdy  = req_rdy;
    assign coh.cohereresp_val = resp_val;
    assign coh.cohereresp_msg = resp_msg;

    plab3_mem_coherence_responder_l1_dpath #(
        .p_opaque_nbits (p_opaque_nbits),
        .p_addr_nbits   (p_addr_nbits),
        .p_line_nbits   (p_line_nbits),
        .p_msg_nbits    (c_msg_nbits)
    ) dpath (
        .clk          (clk),
        .reset        (reset),
        .req_msg      (coh.coherereq_msg),
        .req_sd       (sd),
        .req_load     (req_load),
        .probe_sample (probe_sample),
        .probe_hit    (probe_hit),
        .probe_dirty  (probe_dirty),
        .probe_data   (probe_data),
        .req_type     (req_type),
        .probe_addr   (probe_addr),
        .probe_sd     (probe_sd),
        .resp_msg     (resp_msg)
    );

endmodule

// File: tb/tb_plab3_mem_coherence_responder_l1.sv
// Directed bench for the L1 coherence responder: one task per scenario with
// hand-computed expected responses and strobe counts.
module tb_plab3_mem_coherence_responder_l1;
    import plab3_mem_coherence_responder_l1_pkg::*;

    localparam int O  = 8;
    localparam int A  = 32;
    localparam int C  = 128;
    localparam int MW = 3 + O + A + 4 + C;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    plab3_mem_coherence_responder_l1_if #(.p_opaque_nbits(O), .p_addr_nbits(A), .p_line_nbits(C)) coh_if ();

    logic         probe_en, probe_hit, probe_dirty, inval_en, clean_en, l1_stall, sd, probe_sd;
    logic [A-1:0] probe_addr;
    logic [C-1:0] probe_data;

    plab3_mem_coherence_responder_l1 #(.p_opaque_nbits(O), .p_addr_nbits(A), .p_line_nbits(C)) dut (
        .clk         (clk),
        .reset       (reset),
        .coh         (coh_if),
        .probe_en    (probe_en),
        .probe_addr  (probe_addr),
        .probe_hit   (probe_hit),
        .probe_dirty (probe_dirty),
        .probe_data  (probe_data),
        .inval_en    (inval_en),
        .clean_en    (clean_en),
        .l1_stall    (l1_stall),
        .sd          (sd),
        .probe_sd    (probe_sd)
    );

    int errors = 0;
    int checks = 0;

    logic          obs_acc, obs_stall, obs_probe_en, obs_sd, val_early, obs_val;
    logic          inval_chk, clean_chk;
    logic [A-1:0]  obs_probe_addr;
    logic [MW-1:0] obs_resp;
    int            inval_cnt, clean_cnt;

    function automatic logic [MW-1:0] mk_msg(logic [2:0] t, logic [7:0] op, logic [31:0] a, logic [127:0] d);
        return {t, op, a, 4'd0, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request through PROBE and CHECK into RESP, recording observations
    task automatic do_request(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                              input logic s, input logic hit, input logic dirty, input logic [127:0] d);
        int n;
        coh_if.coherereq_msg = mk_msg(t, op, a, 128'h0);
        coh_if.coherereq_val = 1'b1;
        sd = s;
        n = 0;
        while (!coh_if.coherereq_rdy && n < 20) begin
            tick();
            n++;
        end
        obs_acc = coh_if.coherereq_rdy;
        tick();
        coh_if.coherereq_val = 1'b0;
        coh_if.coherereq_msg = '0;
        sd = 1'b0;
        obs_stall      = l1_stall;
        obs_probe_en   = probe_en;
        obs_probe_addr = probe_addr;
        obs_sd         = probe_sd;
        inval_cnt      = int'(inval_en);
        clean_cnt      = int'(clean_en);
        val_early      = coh_if.cohereresp_val;
        probe_hit   = hit;
        probe_dirty = dirty;
        probe_data  = d;
        tick();
        inval_chk  = inval_en;
        clean_chk  = clean_en;
        inval_cnt += int'(inval_en);
        clean_cnt += int'(clean_en);
        val_early  = val_early | coh_if.cohereresp_val;
        tick();
        probe_hit   = 1'b0;
        probe_dirty = 1'b0;
        probe_data  = '0;
        obs_val    = coh_if.cohereresp_val;
        obs_resp   = coh_if.cohereresp_msg;
        inval_cnt += int'(inval_en);
        clean_cnt += int'(clean_en);
    endtask

    task automatic resp_handshake();
        coh_if.cohereresp_rdy = 1'b1;
        tick();
        coh_if.cohereresp_rdy = 1'b0;
        obs_stall  = l1_stall;
        inval_cnt += int'(inval_en);
        clean_cnt += int'(clean_en);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (coh_if.coherereq_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", coh_if.coherereq_rdy); end
        checks++; if (coh_if.cohereresp_val !== 1'b0) begin errors++; $display("FAIL reset_val: got %b want 0", coh_if.cohereresp_val); end
        checks++; if ({probe_en, inval_en, clean_en, l1_stall, probe_sd} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b want 00000", {probe_en, inval_en, clean_en, l1_stall, probe_sd}); end
        checks++; if (probe_addr !== 32'h0) begin errors++; $display("FAIL reset_probe_addr: got %h want 0", probe_addr); end
        checks++; if (coh_if.cohereresp_msg !== '0) begin errors++; $display("FAIL reset_msg: got %h want 0", coh_if.cohereresp_msg); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_inv_hit();
        do_request(COH_INV, 8'h42, 32'h1000, 1'b0, 1'b1, 1'b0, {32'h12345678, 96'h0});
        checks++; if (obs_acc !== 1'b1) begin errors++; $display("FAIL inv_accept: got %b want 1", obs_acc); end
        checks++; if ({obs_stall, obs_probe_en} !== 2'b11) begin errors++; $display("FAIL inv_probe_en: got %b want 11", {obs_stall, obs_probe_en}); end
        checks++; if (obs_probe_addr !== 32'h1000) begin errors++; $display("FAIL inv_probe_addr: got %h want 00001000", obs_probe_addr); end
        checks++; if ({val_early, obs_val} !== 2'b01) begin errors++; $display("FAIL inv_latency: got early=%b val=%b want 0/1", val_early, obs_val); end
        checks++; if ({inval_chk, clean_chk} !== 2'b10) begin errors++; $display("FAIL inv_strobes: got inval=%b clean=%b want 1/0", inval_chk, clean_chk); end
        checks++; if (obs_resp !== mk_msg(COH_ACK, 8'h42, 32'h1000, 128'h0)) begin errors++; $display("FAIL inv_resp: got %h want %h", obs_resp, mk_msg(COH_ACK, 8'h42, 32'h1000, 128'h0)); end
        resp_handshake();
        checks++; if ({obs_stall, coh_if.coherereq_rdy} !== 2'b01) begin errors++; $display("FAIL inv_idle: got stall/rdy=%b want 01", {obs_stall, coh_if.coherereq_rdy}); end
        checks++; if ({inval_cnt, clean_cnt} !== {32'd1, 32'd0}) begin errors++; $display("FAIL inv_pulse_count: got inval=%0d clean=%0d want 1/0", inval_cnt, clean_cnt); end
    endtask

    task automatic test_wb_dirty();
        logic [127:0] d;
        d = {32'hDEADBEEF, 96'h0};
        do_request(COH_WB, 8'h17, 32'h2004, 1'b1, 1'b1, 1'b1, d);
        checks++; if (obs_probe_addr !== 32'h2000) begin errors++; $display("FAIL wb_probe_addr: got %h want 00002000", obs_probe_addr); end
        checks++; if (obs_sd !== 1'b1) begin errors++; $display("FAIL wb_probe_sd: got %b want 1", obs_sd); end
        checks++; if ({inval_chk, clean_chk} !== 2'b01) begin errors++; $display("FAIL wb_strobes: got inval=%b clean=%b want 0/1", inval_chk, clean_chk); end
        checks++; if (obs_resp !== mk_msg(COH_DATA, 8'h17, 32'h2004, d)) begin errors++; $display("FAIL wb_resp: got %h want %h", obs_resp, mk_msg(COH_DATA, 8'h17, 32'h2004, d)); end
        resp_handshake();
        checks++; if ({inval_cnt, clean_cnt} !== {32'd0, 32'd1}) begin errors++; $display("FAIL wb_pulse_count: got inval=%0d clean=%0d want 0/1", inval_cnt, clean_cnt); end
    endtask

    task automatic test_wbinv();
        logic [127:0] d;
        d = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        do_request(COH_WBINV, 8'h33, 32'h3000, 1'b0, 1'b1, 1'b1, d);
        checks++; if ({inval_chk, clean_chk} !== 2'b10) begin errors++; $display("FAIL wbinv_dirty_strobes: got inval=%b clean=%b want 1/0", inval_chk, clean_chk); end
        checks++; if (obs_resp !== mk_msg(COH_DATA, 8'h33, 32'h3000, d)) begin errors++; $display("FAIL wbinv_dirty_resp: got %h want %h", obs_resp, mk_msg(COH_DATA, 8'h33, 32'h3000, d)); end
        resp_handshake();
        do_request(COH_WBINV, 8'h34, 32'h3000, 1'b0, 1'b1, 1'b0, d);
        checks++; if ({inval_chk, clean_chk} !== 2'b10) begin errors++; $display("FAIL wbinv_clean_strobes: got inval=%b clean=%b want 1/0", inval_chk, clean_chk); end
        checks++; if (obs_resp !== mk_msg(COH_ACK, 8'h34, 32'h3000, 128'h0)) begin errors++; $display("FAIL wbinv_clean_resp: got %h want %h", obs_resp, mk_msg(COH_ACK, 8'h34, 32'h3000, 128'h0)); end
        resp_handshake();
    endtask

    task automatic test_wb_miss();
        do_request(COH_WB, 8'h44, 32'h4000, 1'b0, 1'b0, 1'b1, {96'h0, 32'hCAFEF00D});
        checks++; if ({inval_cnt, clean_cnt} !== {32'd0, 32'd0}) begin errors++; $display("FAIL miss_strobes: got inval=%0d clean=%0d want 0/0", inval_cnt, clean_cnt); end
        checks++; if (obs_resp !== mk_msg(COH_ACK, 8'h44, 32'h4000, 128'h0)) begin errors++; $display("FAIL miss_resp: got %h want %h", obs_resp, mk_msg(COH_ACK, 8'h44, 32'h4000, 128'h0)); end
        resp_handshake();
    endtask

    task automatic test_unknown();
        do_request(3'd5, 8'h55, 32'h4800, 1'b0, 1'b1, 1'b1, {32'hFFFFFFFF, 96'h1});
        checks++; if ({inval_cnt, clean_cnt} !== {32'd0, 32'd0}) begin errors++; $display("FAIL unknown_strobes: got inval=%0d clean=%0d want 0/0", inval_cnt, clean_cnt); end
        checks++; if (obs_resp !== mk_msg(COH_ACK, 8'h55, 32'h4800, 128'h0)) begin errors++; $display("FAIL unknown_resp: got %h want %h", obs_resp, mk_msg(COH_ACK, 8'h55, 32'h4800, 128'h0)); end
        resp_handshake();
    endtask

    task automatic test_back_to_back();
        logic [MW-1:0] exp1;
        int bad;
        exp1 = mk_msg(COH_ACK, 8'h51, 32'h5000, 128'h0);
        do_request(COH_INV, 8'h51, 32'h5000, 1'b0, 1'b1, 1'b0, 128'h0);
        coh_if.coherereq_msg = mk_msg(COH_INV, 8'h52, 32'h6000, 128'h0);
        coh_if.coherereq_val = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({coh_if.cohereresp_val, coh_if.coherereq_rdy} !== 2'b10 || coh_if.cohereresp_msg !== exp1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles want 0", bad); end
        coh_if.cohereresp_rdy = 1'b1;
        tick();
        coh_if.cohereresp_rdy = 1'b0;
        checks++; if ({l1_stall, coh_if.coherereq_rdy} !== 2'b01) begin errors++; $display("FAIL b2b_no_same_cycle: got stall/rdy=%b want 01", {l1_stall, coh_if.coherereq_rdy}); end
        tick();
        coh_if.coherereq_val = 1'b0;
        coh_if.coherereq_msg = '0;
        checks++; if ({l1_stall, probe_en, probe_addr} !== {2'b11, 32'h6000}) begin errors++; $display("FAIL b2b_accept: got stall=%b probe_en=%b addr=%h want 1/1/00006000", l1_stall, probe_en, probe_addr); end
        tick();
        tick();
        checks++; if (coh_if.cohereresp_msg !== mk_msg(COH_ACK, 8'h52, 32'h6000, 128'h0) || coh_if.cohereresp_val !== 1'b1) begin errors++; $display("FAIL b2b_resp: got val=%b msg=%h want 1/%h", coh_if.cohereresp_val, coh_if.cohereresp_msg, mk_msg(COH_ACK, 8'h52, 32'h6000, 128'h0)); end
        resp_handshake();
    endtask

    task automatic test_reset_mid();
        coh_if.coherereq_msg = mk_msg(COH_INV, 8'h61, 32'h7000, 128'h0);
        coh_if.coherereq_val = 1'b1;
        tick();
        coh_if.coherereq_val = 1'b0;
        coh_if.coherereq_msg = '0;
        probe_hit = 1'b1;
        tick();
        checks++; if (inval_en !== 1'b1) begin errors++; $display("FAIL midrst_in_check: got inval=%b want 1", inval_en); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({l1_stall, inval_en, coh_if.cohereresp_val, coh_if.coherereq_rdy} !== 4'b0001) begin errors++; $display("FAIL midrst_async: got stall/inval/val/rdy=%b want 0001", {l1_stall, inval_en, coh_if.cohereresp_val, coh_if.coherereq_rdy}); end
        tick();
        tick();
        probe_hit = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        checks++; if ({l1_stall, coh_if.cohereresp_val} !== 2'b00) begin errors++; $display("FAIL midrst_no_resp: got stall/val=%b want 00", {l1_stall, coh_if.cohereresp_val}); end
        do_request(COH_INV, 8'h62, 32'h8000, 1'b0, 1'b1, 1'b0, 128'h0);
        checks++; if (obs_resp !== mk_msg(COH_ACK, 8'h62, 32'h8000, 128'h0) || obs_val !== 1'b1) begin errors++; $display("FAIL midrst_fresh_resp: got val=%b msg=%h want 1/%h", obs_val, obs_resp, mk_msg(COH_ACK, 8'h62, 32'h8000, 128'h0)); end
        resp_handshake();
        checks++; if ({inval_cnt, clean_cnt} !== {32'd1, 32'd0}) begin errors++; $display("FAIL midrst_fresh_strobes: got inval=%0d clean=%0d want 1/0", inval_cnt, clean_cnt); end
    endtask

    initial begin
        coh_if.coherereq_msg  = '0;
        coh_if.coherereq_val  = 1'b0;
        coh_if.cohereresp_rdy = 1'b0;
        probe_hit   = 1'b0;
        probe_dirty = 1'b0;
        probe_data  = '0;
        sd          = 1'b0;
        reset       = 1'b0;
        test_reset();
        test_inv_hit();
        test_wb_dirty();
        test_wbinv();
        test_wb_miss();
        test_unknown();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
